i2c_byte_controller: RTL and testbench

//  I2C master byte sequencer that drives the SDA module's Read/Select/ShiftOut/StartStopACK controls and generates SCL.

---
 rtl/i2c_byte_controller.sv | 191 +++++++++++++++++++
 tb/tb_i2c_byte_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_controller.sv
// I2C master byte sequencer: optional START, 8 data bits, ACK slot, optional STOP.
// Generates SCL and the Read/Select/ShiftOut/StartStopACK controls for the SDA module.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Go; bus released, or parked low when BusHeld
// START | START or repeated START frame (4 phases)
// DATA  | 8 data bits, MSB first, write or read
// ACK   | ACK slot: sample slave ACK (write) or drive AckOut (read)
// STOP  | STOP frame, then the bus is released
module i2c_byte_controller #(
  parameter int QTR   = 125,
  parameter int QTR_W = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Go,
  input  logic       RW,
  input  logic       SendStart,
  input  logic       SendStop,
  input  logic       AckOut,
  input  logic [7:0] DataIn,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] DataOut,
  output logic       AckIn,
  output logic       SCL,
  output logic       Read,
  output logic       Select,
  output logic       ShiftOut,
  output logic       StartStopACK,
  input  logic       ShiftIn
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP} state_t;

  state_t           state, state_nxt;
  logic [QTR_W-1:0] qcnt;
  logic [1:0]       phase, phase_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rw_q, ack_out_q, stop_q;
  logic             bus_held, bus_held_nxt, done_nxt;
  logic             accept, tick, rw_eff, bit_scl;
  logic             scl_d, read_d, select_d, ssa_d;

  assign accept   = (state == S_IDLE) && Go;
  assign tick     = (qcnt == QTR_W'(QTR - 1));
  // on the accepting edge the captured RW is not yet in rw_q
  assign rw_eff   = accept ? RW : rw_q;
  assign Busy     = (state != S_IDLE);
  // shreg is a flop, so its MSB is already a glitch-free registered output
  assign ShiftOut = shreg[7];

  // State register, datapath and registered bus outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= S_IDLE;
      phase        <= 2'd0;
      qcnt         <= '0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'hFF;
      rw_q         <= 1'b0;
      ack_out_q    <= 1'b1;
      stop_q       <= 1'b0;
      bus_held     <= 1'b0;
      Done         <= 1'b0;
      DataOut      <= 8'h00;
      AckIn        <= 1'b1;
      SCL          <= 1'b1;
      Read         <= 1'b1;
      Select       <= 1'b0;
      StartStopACK <= 1'b1;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      bus_held     <= bus_held_nxt;
      Done         <= done_nxt;
      SCL          <= scl_d;
      Read         <= read_d;
      Select       <= select_d;
      StartStopACK <= ssa_d;
      if (accept) begin
        qcnt      <= '0;
        bit_cnt   <= 3'd7;
        shreg     <= DataIn;
        rw_q      <= RW;
        ack_out_q <= AckOut;
        stop_q    <= SendStop;
      end else if (state != S_IDLE) begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        // ph1 -> ph2 boundary is the sample point while SCL is high
        if (state == S_DATA && tick && phase == 2'd1 && rw_q)
          shreg <= {shreg[6:0], ShiftIn};
        if (state == S_DATA && tick && phase == 2'd3 && bit_cnt != 3'd0) begin
          bit_cnt <= bit_cnt - 1'b1;
          if (!rw_q)
            shreg <= {shreg[6:0], 1'b0};
        end
        if (state == S_ACK && tick && phase == 2'd1 && !rw_q)
          AckIn <= ShiftIn;
      end
      if (done_nxt && rw_q)
        DataOut <= shreg;
    end
  end

  // Next state, phase and bus-hold tracking
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    bus_held_nxt = bus_held;
    done_nxt     = 1'b0;
    if (state == S_IDLE) begin
      if (Go) begin
        state_nxt = (SendStart || !bus_held) ? S_START : S_DATA;
        phase_nxt = 2'd0;
      end
    end else if (tick) begin
      phase_nxt = phase + 2'd1;
      if (phase == 2'd3) begin
        case (state)
          S_START: state_nxt = S_DATA;
          S_DATA:  if (bit_cnt == 3'd0) state_nxt = S_ACK;
          S_ACK: begin
            if (stop_q) begin
              state_nxt = S_STOP;
            end else begin
              state_nxt    = S_IDLE;
              bus_held_nxt = 1'b1;
              done_nxt     = 1'b1;
            end
          end
          S_STOP: begin
            state_nxt    = S_IDLE;
            bus_held_nxt = 1'b0;
            done_nxt     = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Bus levels for the state/phase being entered; registered above
  always_comb begin
    scl_d    = 1'b1;
    read_d   = 1'b1;
    select_d = 1'b0;
    ssa_d    = 1'b1;
    bit_scl  = (phase_nxt == 2'd1) || (phase_nxt == 2'd2);
    case (state_nxt)
      S_IDLE: begin
        if (bus_held_nxt) begin
          scl_d  = 1'b0;
          read_d = 1'b0;
          ssa_d  = 1'b0;
        end
      end
      S_START: begin
        read_d = 1'b0;
        // repeated START starts from a parked-low SCL
        scl_d  = (phase_nxt != 2'd3) && !(phase_nxt == 2'd0 && bus_held);
        ssa_d  = !phase_nxt[1];
      end
      S_DATA: begin
        scl_d = bit_scl;
        if (!rw_eff) begin
          read_d   = 1'b0;
          select_d = 1'b1;
        end
      end
      S_ACK: begin
        scl_d = bit_scl;
        if (rw_eff) begin
          read_d = 1'b0;
          ssa_d  = ack_out_q;
        end
      end
      S_STOP: begin
        read_d = 1'b0;
        scl_d  = (phase_nxt != 2'd0);
        ssa_d  = phase_nxt[1];
      end
      default: begin
        scl_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_controller.sv
// Directed bench for i2c_byte_controller with QTR=2 and a bus-level slave/monitor on SDA.
module tb_i2c_byte_controller;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Go = 1'b0, RW = 1'b0, SendStart = 1'b0, SendStop = 1'b0, AckOut = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       Busy, Done, AckIn, SCL, Read, Select, ShiftOut, StartStopACK, ShiftIn;
  logic [7:0] DataOut;

  logic       sda, slave_sda;
  logic       slave_read = 1'b0, slave_ack = 1'b1;
  logic [7:0] slave_tx = 8'h00;
  int         slave_idx = 9, mon_cnt = 9, n_start = 0, n_stop = 0;
  logic [8:0] mon_shift = 9'h000;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         tests = 0, fails = 0;
  int         cyc, dones, busy1, ds, dp;

  i2c_byte_controller #(.QTR(2), .QTR_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .Go(Go), .RW(RW), .SendStart(SendStart),
    .SendStop(SendStop), .AckOut(AckOut), .DataIn(DataIn), .Busy(Busy), .Done(Done),
    .DataOut(DataOut), .AckIn(AckIn), .SCL(SCL), .Read(Read), .Select(Select),
    .ShiftOut(ShiftOut), .StartStopACK(StartStopACK), .ShiftIn(ShiftIn)
  );

  always #5 Clock = ~Clock;

  assign sda     = Read ? slave_sda : (Select ? ShiftOut : StartStopACK);
  assign ShiftIn = sda;

  // Slave drives read data bits, or an ACK in the ninth slot of a write
  always_comb begin
    slave_sda = 1'b1;
    if (slave_read && slave_idx < 8)
      slave_sda = slave_tx[3'(7 - slave_idx)];
    else if (!slave_read && slave_idx == 8 && slave_ack)
      slave_sda = 1'b0;
  end

  // Bus monitor: START/STOP detection and 9-bit capture on SCL rising edges
  always @(SCL or sda) begin
    if (SCL !== prev_scl) begin
      if (SCL === 1'b1) begin
        if (mon_cnt < 9) begin
          mon_shift = {mon_shift[7:0], sda};
          mon_cnt++;
        end
      end else begin
        slave_idx = mon_cnt;
      end
    end else if (SCL === 1'b1 && sda !== prev_sda) begin
      if (sda === 1'b0) begin
        n_start++;
        mon_cnt   = 0;
        slave_idx = 0;
      end else begin
        n_stop++;
      end
    end
    prev_scl = SCL;
    prev_sda = sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command; optionally re-pulse Go with flipped DataIn at cycle 'poke'
  task automatic do_cmd(input logic rw, input logic st, input logic sp, input logic ao,
                        input logic [7:0] d, input int poke,
                        output int lat, output int nd, output int b1,
                        output int dstart, output int dstop);
    int s0, p0;
    @(negedge Clock);
    s0 = n_start;
    p0 = n_stop;
    Go = 1'b1; RW = rw; SendStart = st; SendStop = sp; AckOut = ao; DataIn = d;
    @(negedge Clock);
    Go  = 1'b0;
    lat = 1;
    b1  = int'(Busy);
    while (Done !== 1'b1 && lat < 400) begin
      if (lat == poke) begin
        Go     = 1'b1;
        DataIn = ~d;
      end else begin
        Go = 1'b0;
      end
      @(negedge Clock);
      lat++;
    end
    Go = 1'b0;
    nd = (Done === 1'b1) ? 1 : 0;
    repeat (12) begin
      @(negedge Clock);
      if (Done === 1'b1) nd++;
    end
    dstart = n_start - s0;
    dstop  = n_stop - p0;
  endtask

  initial begin
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_outputs", {SCL, Read, Select, StartStopACK, ShiftOut, Busy, Done, AckIn}, 8'hD9);
    check("rst_dataout", DataOut, 8'h00);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // write A5, START+STOP, slave ACKs
    slave_read = 1'b0; slave_ack = 1'b1;
    do_cmd(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, -1, cyc, dones, busy1, ds, dp);
    check("a5_latency", cyc, 89);
    check("a5_busy_c1", busy1, 1);
    check("a5_dones", dones, 1);
    check("a5_bus_bits", mon_shift, 9'h14A);
    check("a5_ackin", AckIn, 1'b0);
    check("a5_start_stop", {ds[3:0], dp[3:0]}, 8'h11);
    check("a5_released", {SCL, Read, Busy}, 3'b110);

    // write 3C, no slave ACK: STOP still issued
    slave_ack = 1'b0;
    do_cmd(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, -1, cyc, dones, busy1, ds, dp);
    check("3c_latency", cyc, 89);
    check("3c_bus_bits", mon_shift, 9'h079);
    check("3c_ackin", AckIn, 1'b1);
    check("3c_start_stop", {ds[3:0], dp[3:0]}, 8'h11);
    check("3c_released", {SCL, Read}, 2'b11);

    // write 90 without STOP: bus parked
    slave_ack = 1'b1;
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h90, -1, cyc, dones, busy1, ds, dp);
    check("90_latency", cyc, 81);
    check("90_bus_bits", mon_shift, 9'h120);
    check("90_ackin", AckIn, 1'b0);
    check("90_start_stop", {ds[3:0], dp[3:0]}, 8'h10);
    check("90_parked", {SCL, Read, Select, StartStopACK}, 4'b0000);

    // read with repeated START, slave sends 5E, master NACKs, STOP
    slave_read = 1'b1; slave_tx = 8'h5E;
    do_cmd(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, -1, cyc, dones, busy1, ds, dp);
    check("rd_latency", cyc, 89);
    check("rd_dataout", DataOut, 8'h5E);
    check("rd_bus_bits", mon_shift, 9'h0BD);
    check("rd_start_stop", {ds[3:0], dp[3:0]}, 8'h11);
    check("rd_released", {SCL, Read}, 2'b11);

    // Go re-pulsed while busy with a different DataIn
    slave_read = 1'b0; slave_ack = 1'b1;
    do_cmd(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 40, cyc, dones, busy1, ds, dp);
    check("c3_latency", cyc, 89);
    check("c3_dones", dones, 1);
    check("c3_bus_bits", mon_shift, 9'h186);
    check("c3_dataout_held", DataOut, 8'h5E);

    // reset asserted in bit 4 (ph0) of a write
    @(negedge Clock);
    Go = 1'b1; RW = 1'b0; SendStart = 1'b1; SendStop = 1'b1; DataIn = 8'hF0;
    @(negedge Clock);
    Go = 1'b0;
    repeat (33) @(negedge Clock);
    check("rst_mid_pre", {SCL, Read, Busy}, 3'b001);
    Reset = 1'b0;
    #1;
    check("rst_mid_outs", {SCL, Read, Busy, Done}, 4'b1100);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    check("rst_mid_idle", {Busy, SCL, Read}, 3'b011);

    // SendStart=0 with bus released: START forced
    do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h81, -1, cyc, dones, busy1, ds, dp);
    check("81_latency", cyc, 89);
    check("81_start_stop", {ds[3:0], dp[3:0]}, 8'h11);
    check("81_bus_bits", mon_shift, 9'h102);

    // park, then continue without START from held bus
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h66, -1, cyc, dones, busy1, ds, dp);
    check("66_latency", cyc, 81);
    check("66_parked", {SCL, Read}, 2'b00);
    do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h7E, -1, cyc, dones, busy1, ds, dp);
    check("7e_latency", cyc, 81);
    check("7e_start_stop", {ds[3:0], dp[3:0]}, 8'h01);
    check("7e_ackin", AckIn, 1'b1);
    check("7e_released", {SCL, Read}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
